calc_seq16: RTL and testbench

- Sequences one 16-bit add or subtract as two passes through the shared 8-bit adder datapath: low byte first, then high byte.
- Latches the inter-byte carry between passes, assembles the 16-bit result and drives the carry/borrow indicator LED.
- Sits between the keypad/operand registers and the 8-bit adder; the display logic reads its result outputs.

---
 rtl/calc_seq16.sv | 226 ++++++++++++++++++++++
 tb/tb_calc_seq16.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq16.sv
// calc_seq16: sequences one 16-bit add/subtract as two byte passes through a
// shared external 8-bit adder (low byte first, then high byte), latching the
// inter-byte carry and assembling the 16-bit result plus the carry/borrow lamp.
// Optional feature macro: CALC_SEQ16_OVF_EN adds a registered signed-overflow
// output 'ovf'.
module calc_seq16 #(
  parameter logic [2:0] OP_ADD = 3'b011,
  parameter logic [2:0] OP_SUB = 3'b100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  sign,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_cin,
  output logic        islow,
  input  logic [7:0]  alu_sum,
  input  logic        alu_cout,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        err,
  output logic        led2
`ifdef CALC_SEQ16_OVF_EN
  ,
  output logic        ovf
`endif
);

  localparam int unsigned W  = 16;
  localparam int unsigned BW = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  // Current state and captured operation. Only the high bytes of the operands
  // need holding: the low bytes go straight into the adder-input registers.
  logic [1:0]    r_state;
  logic [BW-1:0] r_a_hi;
  logic [BW-1:0] r_b_hi;
  logic          r_sub;
  logic [BW-1:0] r_res_lo;

  // Registered outputs. r_alu_cin doubles as the inter-byte carry latch
  // during the high-byte pass.
  logic [BW-1:0] r_alu_a;
  logic [BW-1:0] r_alu_b;
  logic          r_alu_cin;
  logic          r_islow;
  logic          r_busy;
  logic          r_done;
  logic [W-1:0]  r_result;
  logic          r_err;
  logic          r_led2;
`ifdef CALC_SEQ16_OVF_EN
  logic          r_ovf;
`endif

  // Next-state values
  logic [1:0]    w_state_nxt;
  logic [BW-1:0] w_a_hi_nxt;
  logic [BW-1:0] w_b_hi_nxt;
  logic          w_sub_nxt;
  logic [BW-1:0] w_res_lo_nxt;
  logic [BW-1:0] w_alu_a_nxt;
  logic [BW-1:0] w_alu_b_nxt;
  logic          w_alu_cin_nxt;
  logic          w_islow_nxt;
  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic [W-1:0]  w_result_nxt;
  logic          w_err_nxt;
  logic          w_led2_nxt;
`ifdef CALC_SEQ16_OVF_EN
  logic          w_ovf_nxt;
`endif
  logic          w_start_sub;
  logic          w_start_ok;

  assign w_start_sub = (sign == OP_SUB);
  assign w_start_ok  = (sign == OP_ADD) || w_start_sub;

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_a_hi_nxt    = r_a_hi;
    w_b_hi_nxt    = r_b_hi;
    w_sub_nxt     = r_sub;
    w_res_lo_nxt  = r_res_lo;
    w_alu_a_nxt   = '0;
    w_alu_b_nxt   = '0;
    w_alu_cin_nxt = 1'b0;
    w_islow_nxt   = 1'b0;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    w_result_nxt  = r_result;
    w_err_nxt     = r_err;
    w_led2_nxt    = r_led2;
`ifdef CALC_SEQ16_OVF_EN
    w_ovf_nxt     = r_ovf;
`endif

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_start_ok) begin
            // Capture operands and present the low-byte pass immediately.
            w_a_hi_nxt    = opa[W-1:BW];
            w_b_hi_nxt    = opb[W-1:BW];
            w_sub_nxt     = w_start_sub;
            w_state_nxt   = S_LOW;
            w_islow_nxt   = 1'b1;
            w_busy_nxt    = 1'b1;
            w_alu_a_nxt   = opa[BW-1:0];
            w_alu_b_nxt   = w_start_sub ? ~opb[BW-1:0] : opb[BW-1:0];
            w_alu_cin_nxt = w_start_sub;
          end else begin
            // Unsupported operator: skip the adder entirely.
            w_state_nxt  = S_FIN;
            w_done_nxt   = 1'b1;
            w_result_nxt = '0;
            w_err_nxt    = 1'b1;
            w_led2_nxt   = 1'b0;
`ifdef CALC_SEQ16_OVF_EN
            w_ovf_nxt    = 1'b0;
`endif
          end
        end
      end

      S_LOW: begin
        // Keep the low sum and feed its carry into the high-byte pass.
        w_res_lo_nxt  = alu_sum;
        w_state_nxt   = S_HIGH;
        w_busy_nxt    = 1'b1;
        w_alu_a_nxt   = r_a_hi;
        w_alu_b_nxt   = r_sub ? ~r_b_hi : r_b_hi;
        w_alu_cin_nxt = alu_cout;
      end

      S_HIGH: begin
        // Final pass: publish result, lamp and flags together with done.
        w_state_nxt  = S_FIN;
        w_done_nxt   = 1'b1;
        w_result_nxt = {alu_sum, r_res_lo};
        w_err_nxt    = 1'b0;
        w_led2_nxt   = r_sub ? ~alu_cout : alu_cout;
`ifdef CALC_SEQ16_OVF_EN
        if (r_sub) begin
          w_ovf_nxt = (r_a_hi[BW-1] != r_b_hi[BW-1]) && (alu_sum[BW-1] != r_a_hi[BW-1]);
        end else begin
          w_ovf_nxt = (r_a_hi[BW-1] == r_b_hi[BW-1]) && (alu_sum[BW-1] != r_a_hi[BW-1]);
        end
`endif
      end

      S_FIN: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_a_hi    <= '0;
      r_b_hi    <= '0;
      r_sub     <= 1'b0;
      r_res_lo  <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_cin <= 1'b0;
      r_islow   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_err     <= 1'b0;
      r_led2    <= 1'b0;
`ifdef CALC_SEQ16_OVF_EN
      r_ovf     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_a_hi    <= w_a_hi_nxt;
      r_b_hi    <= w_b_hi_nxt;
      r_sub     <= w_sub_nxt;
      r_res_lo  <= w_res_lo_nxt;
      r_alu_a   <= w_alu_a_nxt;
      r_alu_b   <= w_alu_b_nxt;
      r_alu_cin <= w_alu_cin_nxt;
      r_islow   <= w_islow_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_result  <= w_result_nxt;
      r_err     <= w_err_nxt;
      r_led2    <= w_led2_nxt;
`ifdef CALC_SEQ16_OVF_EN
      r_ovf     <= w_ovf_nxt;
`endif
    end
  end

  assign alu_a   = r_alu_a;
  assign alu_b   = r_alu_b;
  assign alu_cin = r_alu_cin;
  assign islow   = r_islow;
  assign busy    = r_busy;
  assign done    = r_done;
  assign result  = r_result;
  assign err     = r_err;
  assign led2    = r_led2;
`ifdef CALC_SEQ16_OVF_EN
  assign ovf     = r_ovf;
`endif

endmodule

// File: tb/tb_calc_seq16.sv
// Testbench for calc_seq16: table vectors, randomized ops against an
// arithmetic reference model, and hand sequences for ignored start and reset.
module tb_calc_seq16;

  localparam logic [2:0] ADD = 3'b011;
  localparam logic [2:0] SUB = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  sign;
  logic [15:0] opa, opb;
  logic [7:0]  alu_a, alu_b, alu_sum;
  logic        alu_cin, alu_cout, islow, busy, done, err, led2;
  logic [15:0] result;
`ifdef CALC_SEQ16_OVF_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  // External 8-bit adder the sequencer drives
  assign {alu_cout, alu_sum} = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_cin};

  calc_seq16 dut (
    .clk(clk), .rst(rst), .start(start), .sign(sign), .opa(opa), .opb(opb),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .islow(islow),
    .alu_sum(alu_sum), .alu_cout(alu_cout), .busy(busy), .done(done),
    .result(result), .err(err), .led2(led2)
`ifdef CALC_SEQ16_OVF_EN
    , .ovf(ovf)
`endif
  );

  typedef struct {
    logic [2:0]  s;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        led;
    logic        er;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operator's meaning
  function automatic void model(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic led, output logic er,
                                output logic ov);
    int ua, ub, sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = '0; led = 1'b0; er = 1'b0; ov = 1'b0;
    if (s == ADD) begin
      r   = 16'(ua + ub);
      led = (ua + ub) > 65535;
      sr  = sa + sb;
      ov  = (sr > 32767) || (sr < -32768);
    end else if (s == SUB) begin
      r   = 16'(ua - ub);
      led = ua < ub;
      sr  = sa - sb;
      ov  = (sr > 32767) || (sr < -32768);
    end else begin
      er = 1'b1;
    end
  endfunction

  // One operation: checks pass signals, latency and final outputs
  task automatic run_op(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er_res, input logic e_led, input logic e_err,
                        input logic e_ovf);
    logic        valid, is_sub;
    logic [15:0] bb;
    logic [8:0]  lo;
    int          cyc;
    valid  = (s == ADD) || (s == SUB);
    is_sub = (s == SUB);
    bb     = is_sub ? ~b : b;
    lo     = {1'b0, a[7:0]} + {1'b0, bb[7:0]} + {8'b0, is_sub};
    @(negedge clk);
    start = 1'b1; sign = s; opa = a; opb = b;
    @(negedge clk);
    start = 1'b0; sign = 3'($urandom); opa = 16'($urandom); opb = 16'($urandom);
    cyc = 1;
    chk("islow_n1", 32'(islow), 32'(valid));
    chk("alu_a_low", 32'(alu_a), valid ? 32'(a[7:0]) : 32'd0);
    chk("alu_b_low", 32'(alu_b), valid ? 32'(bb[7:0]) : 32'd0);
    chk("cin_low", 32'(alu_cin), 32'(is_sub));
    chk("busy_n1", 32'(busy), 32'(valid));
    if (valid) begin
      @(negedge clk);
      cyc = 2;
      chk("islow_high", 32'(islow), 32'd0);
      chk("alu_a_high", 32'(alu_a), 32'(a[15:8]));
      chk("alu_b_high", 32'(alu_b), 32'(bb[15:8]));
      chk("cin_high", 32'(alu_cin), 32'(lo[8]));
    end
    while (!done && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), valid ? 32'd3 : 32'd1);
    chk("done", 32'(done), 32'd1);
    chk("busy_fin", 32'(busy), 32'd0);
    chk("result", 32'(result), 32'(er_res));
    chk("led2", 32'(led2), 32'(e_led));
    chk("err", 32'(err), 32'(e_err));
`ifdef CALC_SEQ16_OVF_EN
    chk("ovf", 32'(ovf), 32'(e_ovf));
`else
    if (e_ovf === 1'bx) $display("note: unknown ovf expectation");
`endif
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] m_r;
    logic        m_led, m_err, m_ovf;
    logic [2:0]  rs;
    int          ndone;

    vecs[0] = '{ADD,    16'h1234, 16'h0101, 16'h1335, 1'b0, 1'b0};
    vecs[1] = '{ADD,    16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0};
    vecs[2] = '{ADD,    16'hFFFF, 16'h0002, 16'h0001, 1'b1, 1'b0};
    vecs[3] = '{SUB,    16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0};
    vecs[4] = '{SUB,    16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0};
    vecs[5] = '{3'b001, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1};
    vecs[6] = '{SUB,    16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{3'b111, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1};
    vecs[8] = '{ADD,    16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0};
    vecs[9] = '{ADD,    16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; sign = '0; opa = '0; opb = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_led2", 32'(led2), 32'd0);
    chk("rst_islow", 32'(islow), 32'd0);
    chk("rst_alu", 32'({alu_a, alu_b, alu_cin}), 32'd0);
    rst = 1'b0;

    // Table vectors, issued back-to-back
    for (int i = 0; i < 10; i++) begin
      model(vecs[i].s, vecs[i].a, vecs[i].b, m_r, m_led, m_err, m_ovf);
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].led, vecs[i].er, m_ovf);
    end
`ifdef CALC_SEQ16_OVF_EN
    chk("ovf_7fff_plus_1", 32'(ovf), 32'd1);
`endif

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       rs = ADD;
        1:       rs = SUB;
        2:       rs = 3'($urandom);
        default: rs = SUB;
      endcase
      opa = 16'($urandom);
      opb = 16'($urandom);
      begin
        logic [15:0] ra, rb;
        ra = opa; rb = opb;
        model(rs, ra, rb, m_r, m_led, m_err, m_ovf);
        run_op(rs, ra, rb, m_r, m_led, m_err, m_ovf);
      end
    end

    // start during HIGH and during FIN is ignored; one done, result held
    @(negedge clk);
    start = 1'b1; sign = ADD; opa = 16'h1234; opb = 16'h0101;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; sign = SUB; opa = 16'hFFFF; opb = 16'h0001;
    @(negedge clk);
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_result", 32'(result), 32'h1335);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("ign_extra_done", 32'(ndone), 32'd0);
    chk("ign_hold", 32'(result), 32'h1335);
    chk("ign_busy", 32'(busy), 32'd0);

    // Reset during HIGH aborts with no done pulse
    @(negedge clk);
    start = 1'b1; sign = ADD; opa = 16'h00FF; opb = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_cin", 32'(alu_cin), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_led2", 32'(led2), 32'd0);
    chk("abort_islow", 32'(islow), 32'd0);
    chk("abort_alu", 32'({alu_a, alu_b, alu_cin}), 32'd0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    // Recovery after abort
    model(SUB, 16'h0100, 16'h0001, m_r, m_led, m_err, m_ovf);
    run_op(SUB, 16'h0100, 16'h0001, m_r, m_led, m_err, m_ovf);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
